// File: rtl/dtc_pkg.sv
// Shared types and widths for the table-driven decision-tree walker.
// Node layout, FSM state codes and the reset node used by the table.
package dtc_pkg;

    localparam int N_FEAT = 12;
    localparam int OUT_W = 3;
    localparam int N_NODES = 32;
    localparam int DEPTH_MAX_DEF = 8;

    localparam int FEAT_W = $clog2(N_FEAT);
    localparam int PTR_W = $clog2(N_NODES);
    localparam int NODE_W = 1 + FEAT_W + 2 * PTR_W + OUT_W;

    typedef struct packed {
        logic              is_leaf;
        logic [FEAT_W-1:0] feat_idx;
        logic [PTR_W-1:0]  lo_idx;
        logic [PTR_W-1:0]  hi_idx;
        logic [OUT_W-1:0]  leaf_class;
    } node_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WALK = ST_WALK,
        DONE = ST_DONE
    } state_e;

    localparam node_t RST_NODE = node_t'{1'b1, '0, '0, '0, '0};

    function automatic node_t mk_node(
        input logic              leaf,
        input logic [FEAT_W-1:0] feat,
        input logic [PTR_W-1:0]  lo,
        input logic [PTR_W-1:0]  hi,
        input logic [OUT_W-1:0]  cls
    );
        return node_t'{leaf, feat, lo, hi, cls};
    endfunction

endpackage

// File: rtl/dtc_node_table.sv
// Runtime-loadable node table: one write port, one combinational read.
// Every entry resets to a class-0 leaf so an unloaded tree is harmless.
module dtc_node_table
    import dtc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  node_t            wdata,
    input  logic [PTR_W-1:0] raddr,
    output node_t            rdata
);

    node_t mem [N_NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) begin
                mem[i] <= RST_NODE;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtc_walker.sv
// Sequential decision-tree classifier walking one node per cycle.
// Optional DTC_WALKER_PERF_EN adds perf_count and out_depth ports.
module dtc_walker
    import dtc_pkg::*;
#(
    parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PTR_W-1:0]  cfg_addr,
    input  logic [NODE_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_class,
    output logic              out_err
`ifdef DTC_WALKER_PERF_EN
    ,
    output logic [31:0]       perf_count,
    output logic [$clog2(DEPTH_MAX+1)-1:0] out_depth
`endif
);

    localparam int DW = $clog2(DEPTH_MAX + 1);

    logic [1:0]        state;
    logic [N_FEAT-1:0] feat_q;
    logic [PTR_W-1:0]  ptr;
    logic [DW-1:0]     depth;
    logic              err_pend;
    logic              tbl_we;
    logic              bad_feat;
    logic              at_limit;
    node_t             node;

    assign tbl_we = cfg_we && (state == ST_IDLE)
                 && (32'(cfg_addr) < N_NODES);

    dtc_node_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (node_t'(cfg_data)),
        .raddr (ptr),
        .rdata (node)
    );

    assign bad_feat = 32'(node.feat_idx) >= N_FEAT;
    assign at_limit = depth == DW'(DEPTH_MAX - 1);

    assign in_ready = state == ST_IDLE;
    assign cfg_ready = state == ST_IDLE;
    assign out_valid = state == ST_DONE;

    // An abort is counted as a visited internal node, so it costs one
    // extra WALK cycle before the error result is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            feat_q <= '0;
            ptr <= '0;
            depth <= '0;
            err_pend <= 1'b0;
            out_class <= '0;
            out_err <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_q <= in_feat;
                        ptr <= '0;
                        depth <= '0;
                        err_pend <= 1'b0;
                        state <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (err_pend) begin
                        out_class <= '0;
                        out_err <= 1'b1;
                        state <= ST_DONE;
                    end else if (node.is_leaf) begin
                        out_class <= node.leaf_class;
                        out_err <= 1'b0;
                        state <= ST_DONE;
                    end else if (bad_feat || at_limit) begin
                        err_pend <= 1'b1;
                        depth <= depth + 1'b1;
                    end else begin
                        ptr <= feat_q[node.feat_idx] ? node.hi_idx
                                                     : node.lo_idx;
                        depth <= depth + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DTC_WALKER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count <= '0;
            out_depth <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_count <= perf_count + 32'd1;
            end
            if (state == ST_WALK && (err_pend || node.is_leaf)) begin
                out_depth <= depth;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dtc_walker.sv
// Randomised bench for dtc_walker against a path-walking reference model.
// Directed cases pin latencies and classes of the reference trees.
module tb_dtc_walker;
    import dtc_pkg::*;

    localparam int DM = 8;
    localparam int DEPW = $clog2(DM + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cfg_we = 1'b0;
    logic [PTR_W-1:0]  cfg_addr = '0;
    logic [NODE_W-1:0] cfg_data = '0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_FEAT-1:0] in_feat = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_class;
    logic              out_err;
`ifdef DTC_WALKER_PERF_EN
    logic [31:0]       perf_count;
    logic [DEPW-1:0]   out_depth;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dtc_walker #(.DEPTH_MAX(DM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err)
`ifdef DTC_WALKER_PERF_EN
        ,
        .perf_count (perf_count),
        .out_depth  (out_depth)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: the table as the bench believes it is, plus a
    // coarse handshake phase (0 idle, 1 busy, 2 result pending).
    node_t           tab [N_NODES];
    int              m_st;
    int              m_wait;
    logic [OUT_W-1:0] m_class;
    logic            m_err;
    int              m_k;
    logic [31:0]     m_perf;

    function automatic void classify(input logic [N_FEAT-1:0] f,
                                     output logic [OUT_W-1:0] c,
                                     output logic e, output int k);
        int p;
        node_t n;
        p = 0;
        k = 0;
        c = '0;
        e = 1'b0;
        for (int i = 0; i < 4 * N_NODES; i++) begin
            n = tab[p];
            if (n.is_leaf) begin
                c = n.leaf_class;
                return;
            end
            k++;
            if (int'(n.feat_idx) >= N_FEAT || k == DM) begin
                e = 1'b1;
                return;
            end
            p = f[n.feat_idx] ? int'(n.hi_idx) : int'(n.lo_idx);
        end
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N_NODES; i++) tab[i] = RST_NODE;
        m_st = 0;
        m_wait = 0;
        m_class = '0;
        m_err = 1'b0;
        m_k = 0;
        m_perf = '0;
    endtask

    task automatic m_step();
        case (m_st)
            0: begin
                if (cfg_we) tab[cfg_addr] = node_t'(cfg_data);
                if (in_valid) begin
                    classify(in_feat, m_class, m_err, m_k);
                    m_wait = m_k + 1;
                    m_st = 1;
                end
            end
            1: begin
                m_wait--;
                if (m_wait == 0) m_st = 2;
            end
            default: begin
                if (out_ready) begin
                    m_st = 0;
                    m_perf++;
                end
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, m_st == 0);
            chk("cfg_ready", cfg_ready, m_st == 0);
            chk("out_valid", out_valid, m_st == 2);
            if (m_st == 2) begin
                chk("out_class", out_class, m_class);
                chk("out_err", out_err, m_err);
`ifdef DTC_WALKER_PERF_EN
                chk("out_depth", out_depth, m_k);
`endif
            end
`ifdef DTC_WALKER_PERF_EN
            chk("perf_count", perf_count, m_perf);
`endif
        end
    end

    task automatic wr(input int a, input node_t n);
        cfg_we = 1'b1;
        cfg_addr = PTR_W'(a);
        cfg_data = n;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic txn(input logic [N_FEAT-1:0] f, input logic [2:0] ec,
                       input logic ee, input int el, input string nm);
        int lat;
        in_valid = 1'b1;
        in_feat = f;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_cls"}, out_class, ec);
        chk({nm, "_err"}, out_err, ee);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic node_t rnd_node();
        return mk_node($urandom_range(0, 99) < 35,
                       FEAT_W'($urandom_range(0, 13)),
                       PTR_W'($urandom), PTR_W'($urandom),
                       OUT_W'($urandom));
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [OUT_W-1:0] c;
        logic e;
        int k;
        int w;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_err", out_err, 0);

        txn(12'h000, 3'd0, 1'b0, 2, "empty");

        // Reference tree: f6 -> f3 -> f4 on the bit6-clear side.
        wr(0, mk_node(1'b0, 4'd6, 5'd1, 5'd2, 3'd0));
        wr(1, mk_node(1'b0, 4'd3, 5'd3, 5'd4, 3'd0));
        wr(2, mk_node(1'b0, 4'd0, 5'd5, 5'd6, 3'd0));
        wr(3, mk_node(1'b1, 4'd0, 5'd0, 5'd0, 3'b000));
        wr(4, mk_node(1'b0, 4'd4, 5'd7, 5'd8, 3'd0));
        wr(5, mk_node(1'b1, 4'd0, 5'd0, 5'd0, 3'b100));
        wr(6, mk_node(1'b1, 4'd0, 5'd0, 5'd0, 3'b100));
        wr(7, mk_node(1'b1, 4'd0, 5'd0, 5'd0, 3'b001));
        wr(8, mk_node(1'b1, 4'd0, 5'd0, 5'd0, 3'b111));
        @(negedge clk);
        classify(12'h019, c, e, k);
        chk("mdl_ref_cls", c, 3'b111);
        chk("mdl_ref_k", k, 3);

        txn(12'h019, 3'b111, 1'b0, 5, "ref_hi");
        txn(12'h009, 3'b001, 1'b0, 5, "ref_lo");
        txn(12'h040, 3'b100, 1'b0, 4, "ref_b6");

        // Stall in DONE; a write here must not reach the table.
        in_valid = 1'b1;
        in_feat = 12'h019;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            cfg_we = 1'b1;
            cfg_addr = '0;
            cfg_data = mk_node(1'b1, 4'd0, 5'd0, 5'd0, 3'd5);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_cls", out_class, 3'b111);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        txn(12'h019, 3'b111, 1'b0, 5, "readback");

        wr(0, mk_node(1'b0, 4'd13, 5'd1, 5'd2, 3'd0));
        txn(12'h000, 3'd0, 1'b1, 3, "bad_feat");

        wr(0, mk_node(1'b0, 4'd0, 5'd1, 5'd1, 3'd0));
        wr(1, mk_node(1'b0, 4'd0, 5'd0, 5'd0, 3'd0));
        classify(12'hfff, c, e, k);
        chk("mdl_cyc_err", e, 1);
        chk("mdl_cyc_k", k, DM);
        txn(12'hfff, 3'd0, 1'b1, DM + 2, "cyclic");

        // Reset in the middle of a walk on the cyclic table.
        in_valid = 1'b1;
        in_feat = 12'h000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(12'h000, 3'd0, 1'b0, 2, "after_rst");

        for (int i = 0; i < N_NODES; i++) wr(i, rnd_node());
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cfg_we = $urandom_range(0, 9) < 2;
            cfg_addr = PTR_W'($urandom);
            cfg_data = rnd_node();
            in_valid = $urandom_range(0, 1) == 1;
            in_feat = N_FEAT'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
